// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage program-counter sequencer: handshake advance, redirect/flush window, halt/resume.
// Optional performance counters are enabled by defining FETCH_PC_CTRL_PERF_EN.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_ready,
    output logic [31:0] pc_out,
    output logic        pc_valid,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        flush_out,
    input  logic        halt_req,
    input  logic        resume,
    output logic [1:0]  state_out
`ifdef FETCH_PC_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_redirect_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] CNT_RELOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state_q;
    logic [31:0] pc_q;
    logic        pc_valid_q;
    logic        flush_q;
    logic [3:0]  cnt_q;

    logic        accept;
    logic        redirect_take;

    assign accept        = pc_valid_q & fetch_ready;
    // Redirects are ignored only in the single post-reset IDLE cycle.
    assign redirect_take = redirect_valid & (state_q != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            cnt_q      <= 4'd0;
        end else begin
            flush_q <= 1'b0;
            if (redirect_take) begin
                state_q    <= S_FLUSH;
                pc_q       <= {redirect_pc[31:2], 2'b00};
                pc_valid_q <= 1'b0;
                flush_q    <= 1'b1;
                cnt_q      <= CNT_RELOAD;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (halt_req) begin
                            state_q    <= S_HALT;
                            pc_valid_q <= 1'b0;
                        end else begin
                            state_q    <= S_RUN;
                            pc_valid_q <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        // An accepted PC is consumed even when halting in the same cycle.
                        if (accept) begin
                            pc_q <= pc_q + 32'd4;
                        end
                        if (halt_req) begin
                            state_q    <= S_HALT;
                            pc_valid_q <= 1'b0;
                        end else begin
                            pc_valid_q <= 1'b1;
                        end
                    end
                    S_FLUSH: begin
                        if (cnt_q == 4'd0) begin
                            if (halt_req) begin
                                state_q    <= S_HALT;
                                pc_valid_q <= 1'b0;
                            end else begin
                                state_q    <= S_RUN;
                                pc_valid_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                    S_HALT: begin
                        if (!halt_req && resume) begin
                            state_q    <= S_RUN;
                            pc_valid_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q    <= S_IDLE;
                        pc_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pc_out    = pc_q;
    assign pc_valid  = pc_valid_q;
    assign flush_out = flush_q;
    assign state_out = state_q;

`ifdef FETCH_PC_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] redirect_cnt_q;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q    <= 32'd0;
            redirect_cnt_q <= 32'd0;
        end else begin
            if (pc_valid_q && !fetch_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (redirect_take && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt    = stall_cnt_q;
    assign perf_redirect_cnt = redirect_cnt_q;
`endif

endmodule
